// File: rtl/uart_bus_pkg.sv
// Shared constants for the bus-mapped UART: register map, STATUS bit positions
// and the state encoding used by both the TX and RX machines.
package uart_bus_pkg;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CLEAR   = 2'd2;
  localparam logic [1:0] REG_BAUDDIV = 2'd3;

  localparam int STAT_RX_AVAIL  = 0;
  localparam int STAT_TX_BUSY   = 1;
  localparam int STAT_RX_FULL   = 2;
  localparam int STAT_OVERRUN   = 3;
  localparam int STAT_FRAME_ERR = 4;

  localparam logic [15:0] DIV_MIN = 16'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous byte FIFO for received UART data. A push while full is
// accepted only when a pop frees the head slot in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [7:0] i_data,
  output logic [7:0] o_head,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign o_full  = (count == CW'(DEPTH));
  assign o_empty = (count == '0);
  assign o_head  = mem[rd_ptr];
  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_bus_responder.sv
// Memory-mapped 8N1 UART on the MasterShell bus: TX byte register, RX FIFO,
// sticky error flags and a runtime baud divisor latched at each frame start.
//
// state   | TX meaning                    | RX meaning
// S_IDLE  | line high, waiting for a load | waiting for falling edge
// S_START | driving start bit             | mid-start check (glitch reject)
// S_DATA  | driving bits 0..7, LSB first  | sampling bits 0..7, LSB first
// S_STOP  | driving stop bit              | stop check / wait for line high
module uart_bus_responder
  import uart_bus_pkg::*;
#(
  parameter int CLK_HZ     = 25000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [1:0]  i_addr,
  input  logic [15:0] i_dat,
  output logic [15:0] o_dat,
  input  logic        i_cs,
  input  logic        i_we,
  output logic        o_ack,
  input  logic        i_uart_rx,
  output logic        o_uart_tx,
  output logic        o_rx_avail
);

  localparam logic [15:0] DIV_RESET = 16'(CLK_HZ / BAUD);

  logic [15:0] div_reg;
  logic        ack_armed;
  logic        access;
  logic        overrun;
  logic        frame_err;
  logic [15:0] status;

  logic [7:0]  fifo_head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_pop;
  logic        rx_push;
  logic        rx_ferr_set;

  uart_state_e tx_state;
  logic [15:0] tx_cnt;
  logic [15:0] tx_div;
  logic [7:0]  tx_shift;
  logic [2:0]  tx_idx;
  logic        tx_busy;
  logic        tx_load;

  uart_state_e rx_state;
  logic [15:0] rx_cnt;
  logic [15:0] rx_div;
  logic [7:0]  rx_shift;
  logic [2:0]  rx_idx;
  logic        rx_brk;
  logic        rx_s1, rx_s2, rx_s3;

  // An access fires once; i_cs must be seen low again before the next one.
  assign access      = i_cs && !o_ack && ack_armed;
  assign tx_busy     = (tx_state != S_IDLE);
  assign tx_load     = access && i_we && (i_addr == REG_DATA) && !tx_busy;
  assign fifo_pop    = access && !i_we && (i_addr == REG_DATA) && !fifo_empty;
  assign rx_push     = (rx_state == S_STOP) && (rx_cnt == '0) && !rx_brk && rx_s2;
  assign rx_ferr_set = (rx_state == S_STOP) && (rx_cnt == '0) && !rx_brk && !rx_s2;
  assign o_rx_avail  = !fifo_empty;

  always_comb begin
    status                 = '0;
    status[STAT_RX_AVAIL]  = !fifo_empty;
    status[STAT_TX_BUSY]   = tx_busy;
    status[STAT_RX_FULL]   = fifo_full;
    status[STAT_OVERRUN]   = overrun;
    status[STAT_FRAME_ERR] = frame_err;
  end

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (rx_push),
    .i_pop   (fifo_pop),
    .i_data  (rx_shift),
    .o_head  (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_ack     <= 1'b0;
      o_dat     <= '0;
      ack_armed <= 1'b1;
      div_reg   <= DIV_RESET;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      o_ack <= access;
      if (access)     ack_armed <= 1'b0;
      else if (!i_cs) ack_armed <= 1'b1;

      if (access && !i_we) begin
        case (i_addr)
          REG_DATA:   o_dat <= fifo_empty ? 16'h0000 : {8'h00, fifo_head};
          REG_STATUS: o_dat <= status;
          REG_CLEAR:  o_dat <= 16'h0000;
          default:    o_dat <= div_reg;
        endcase
      end

      if (access && i_we && (i_addr == REG_BAUDDIV))
        div_reg <= (i_dat < DIV_MIN) ? DIV_MIN : i_dat;

      // A new error event wins over a clear issued in the same cycle.
      if (rx_push && fifo_full && !fifo_pop)
        overrun <= 1'b1;
      else if (access && i_we && (i_addr == REG_CLEAR) && i_dat[STAT_OVERRUN])
        overrun <= 1'b0;

      if (rx_ferr_set)
        frame_err <= 1'b1;
      else if (access && i_we && (i_addr == REG_CLEAR) && i_dat[STAT_FRAME_ERR])
        frame_err <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tx_state  <= S_IDLE;
      o_uart_tx <= 1'b1;
      tx_cnt    <= '0;
      tx_div    <= '0;
      tx_shift  <= '0;
      tx_idx    <= '0;
    end else begin
      case (tx_state)
        S_IDLE: begin
          o_uart_tx <= 1'b1;
          if (tx_load) begin
            tx_shift  <= i_dat[7:0];
            tx_div    <= div_reg;
            tx_cnt    <= div_reg - 16'd1;
            tx_state  <= S_START;
            o_uart_tx <= 1'b0;
          end
        end
        S_START: begin
          if (tx_cnt == '0) begin
            tx_state  <= S_DATA;
            tx_cnt    <= tx_div - 16'd1;
            tx_idx    <= '0;
            o_uart_tx <= tx_shift[0];
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (tx_cnt == '0) begin
            tx_cnt <= tx_div - 16'd1;
            if (tx_idx == 3'd7) begin
              tx_state  <= S_STOP;
              o_uart_tx <= 1'b1;
            end else begin
              tx_idx    <= tx_idx + 3'd1;
              o_uart_tx <= tx_shift[1];
              tx_shift  <= {1'b0, tx_shift[7:1]};
            end
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        S_STOP: begin
          if (tx_cnt == '0) tx_state <= S_IDLE;
          else              tx_cnt   <= tx_cnt - 16'd1;
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_div   <= '0;
      rx_shift <= '0;
      rx_idx   <= '0;
      rx_brk   <= 1'b0;
    end else begin
      rx_s1 <= i_uart_rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
      case (rx_state)
        S_IDLE: begin
          rx_brk <= 1'b0;
          if (rx_s3 && !rx_s2) begin
            rx_state <= S_START;
            rx_div   <= div_reg;
            rx_cnt   <= {1'b0, div_reg[15:1]} - 16'd1;
          end
        end
        S_START: begin
          if (rx_cnt == '0) begin
            if (rx_s2) begin
              rx_state <= S_IDLE;
            end else begin
              rx_state <= S_DATA;
              rx_cnt   <= rx_div - 16'd1;
              rx_idx   <= '0;
            end
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (rx_cnt == '0) begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_cnt   <= rx_div - 16'd1;
            if (rx_idx == 3'd7) rx_state <= S_STOP;
            else                rx_idx   <= rx_idx + 3'd1;
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        S_STOP: begin
          // After a bad stop bit, hold here until the line returns high.
          if (rx_brk) begin
            if (rx_s2) rx_state <= S_IDLE;
          end else if (rx_cnt == '0) begin
            if (rx_s2) rx_state <= S_IDLE;
            else       rx_brk   <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_responder.sv
// Directed bench for uart_bus_responder: register table, TX waveform, RX
// frames, FIFO overrun, framing error, glitch reject and async reset.
module tb_uart_bus_responder;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [1:0]  i_addr = '0;
  logic [15:0] i_dat = '0;
  logic [15:0] o_dat;
  logic        i_cs = 1'b0;
  logic        i_we = 1'b0;
  logic        o_ack;
  logic        i_uart_rx = 1'b1;
  logic        o_uart_tx;
  logic        o_rx_avail;

  int n_pass = 0;
  int n_total = 0;

  localparam int BIT = 4;

  uart_bus_responder dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_addr     (i_addr),
    .i_dat      (i_dat),
    .o_dat      (o_dat),
    .i_cs       (i_cs),
    .i_we       (i_we),
    .o_ack      (o_ack),
    .i_uart_rx  (i_uart_rx),
    .o_uart_tx  (o_uart_tx),
    .o_rx_avail (o_rx_avail)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic bus(input logic [1:0] a, input logic w, input logic [15:0] d,
                     output logic [15:0] rd);
    int lat;
    @(negedge i_clk);
    i_addr = a; i_we = w; i_dat = d; i_cs = 1'b1;
    lat = 99;
    for (int i = 1; i <= 8; i++) begin
      @(negedge i_clk);
      if (o_ack) begin
        lat = i;
        break;
      end
    end
    chk("ack_latency", lat, 1);
    rd = o_dat;
    i_cs = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(negedge i_clk);
    i_uart_rx = 1'b0;
    repeat (BIT) @(negedge i_clk);
    for (int i = 0; i < 8; i++) begin
      i_uart_rx = b[i];
      repeat (BIT) @(negedge i_clk);
    end
    i_uart_rx = stop;
    repeat (BIT) @(negedge i_clk);
    i_uart_rx = 1'b1;
    repeat (BIT) @(negedge i_clk);
  endtask

  typedef struct {
    logic [1:0]  a;
    logic        we;
    logic [15:0] d;
    logic [15:0] exp;
  } vec_t;

  vec_t        vt[13];
  logic [15:0] rd;
  logic        tx_cap[64];
  logic [9:0]  frm;
  int          acks;

  initial begin
    vt[0]  = '{2'd3, 1'b0, 16'h0000, 16'd217};
    vt[1]  = '{2'd3, 1'b1, 16'h0002, 16'h0000};
    vt[2]  = '{2'd3, 1'b0, 16'h0000, 16'h0004};
    vt[3]  = '{2'd3, 1'b1, 16'h0000, 16'h0000};
    vt[4]  = '{2'd3, 1'b0, 16'h0000, 16'h0004};
    vt[5]  = '{2'd3, 1'b1, 16'h1234, 16'h0000};
    vt[6]  = '{2'd3, 1'b0, 16'h0000, 16'h1234};
    vt[7]  = '{2'd1, 1'b1, 16'hFFFF, 16'h0000};
    vt[8]  = '{2'd1, 1'b0, 16'h0000, 16'h0000};
    vt[9]  = '{2'd2, 1'b0, 16'h0000, 16'h0000};
    vt[10] = '{2'd0, 1'b0, 16'h0000, 16'h0000};
    vt[11] = '{2'd3, 1'b1, 16'h0004, 16'h0000};
    vt[12] = '{2'd3, 1'b0, 16'h0000, 16'h0004};

    repeat (3) @(negedge i_clk);
    chk("reset_tx", o_uart_tx, 1);
    chk("reset_ack", o_ack, 0);
    chk("reset_dat", o_dat, 0);
    chk("reset_avail", o_rx_avail, 0);
    i_reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      bus(vt[i].a, vt[i].we, vt[i].d, rd);
      if (!vt[i].we) chk($sformatf("vec%0d_rd", i), rd, vt[i].exp);
    end

    // cs held high across the ack must give exactly one ack
    @(negedge i_clk);
    i_addr = 2'd3; i_we = 1'b0; i_cs = 1'b1;
    acks = 0;
    repeat (5) begin
      @(negedge i_clk);
      if (o_ack) acks++;
    end
    chk("held_cs_acks", acks, 1);
    i_cs = 1'b0;

    // TX frame of A5 while probing busy and a dropped second write
    frm = {1'b1, 8'hA5, 1'b0};
    bus(2'd0, 1'b1, 16'h00A5, rd);
    fork
      begin
        for (int k = 0; k < 64; k++) begin
          tx_cap[k] = o_uart_tx;
          @(negedge i_clk);
        end
      end
      begin
        bus(2'd1, 1'b0, 16'h0, rd);
        chk("tx_busy_mid", rd[1], 1);
        bus(2'd0, 1'b1, 16'h00FF, rd);
        bus(2'd1, 1'b0, 16'h0, rd);
        chk("tx_busy_late", rd[1], 1);
      end
    join
    for (int k = 0; k < 64; k++)
      chk($sformatf("tx_bit_c%0d", k), tx_cap[k], (k < 40) ? frm[k / 4] : 1'b1);
    bus(2'd1, 1'b0, 16'h0, rd);
    chk("tx_idle_status", rd, 16'h0000);

    // single RX byte
    send_rx(8'h3C, 1'b1);
    chk("rx_avail", o_rx_avail, 1);
    bus(2'd0, 1'b0, 16'h0, rd);
    chk("rx_data", rd, 16'h003C);
    bus(2'd1, 1'b0, 16'h0, rd);
    chk("rx_status_after", rd, 16'h0000);

    // overrun
    for (int i = 1; i <= 5; i++) send_rx(8'(i), 1'b1);
    bus(2'd1, 1'b0, 16'h0, rd);
    chk("ovr_status", rd, 16'h000D);
    for (int i = 1; i <= 4; i++) begin
      bus(2'd0, 1'b0, 16'h0, rd);
      chk($sformatf("ovr_rd%0d", i), rd, 16'(i));
    end
    bus(2'd0, 1'b0, 16'h0, rd);
    chk("ovr_rd_empty", rd, 16'h0000);
    bus(2'd1, 1'b0, 16'h0, rd);
    chk("ovr_sticky", rd, 16'h0008);
    bus(2'd2, 1'b1, 16'h0008, rd);
    bus(2'd1, 1'b0, 16'h0, rd);
    chk("ovr_cleared", rd, 16'h0000);

    // framing error
    send_rx(8'h55, 1'b0);
    repeat (4) @(negedge i_clk);
    bus(2'd1, 1'b0, 16'h0, rd);
    chk("ferr_status", rd, 16'h0010);
    chk("ferr_no_byte", o_rx_avail, 0);
    bus(2'd2, 1'b1, 16'h0010, rd);
    bus(2'd1, 1'b0, 16'h0, rd);
    chk("ferr_cleared", rd, 16'h0000);

    // one-cycle glitch
    @(negedge i_clk);
    i_uart_rx = 1'b0;
    @(negedge i_clk);
    i_uart_rx = 1'b1;
    repeat (20) @(negedge i_clk);
    bus(2'd1, 1'b0, 16'h0, rd);
    chk("glitch_status", rd, 16'h0000);

    // async reset in the middle of a TX frame, during an ack cycle
    bus(2'd0, 1'b1, 16'h0000, rd);
    repeat (6) @(negedge i_clk);
    chk("pre_rst_tx", o_uart_tx, 0);
    i_addr = 2'd1; i_we = 1'b0; i_cs = 1'b1;
    @(negedge i_clk);
    chk("pre_rst_ack", o_ack, 1);
    #2;
    i_reset = 1'b1;
    i_cs = 1'b0;
    #1;
    chk("rst_tx_async", o_uart_tx, 1);
    chk("rst_ack_async", o_ack, 0);
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    bus(2'd1, 1'b0, 16'h0, rd);
    chk("post_rst_status", rd, 16'h0000);
    bus(2'd3, 1'b0, 16'h0, rd);
    chk("post_rst_div", rd, 16'd217);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
